// File: rtl/lock_code_sender_pkg.sv
// Shared definitions for the lock code sender.
//   state_e        : FSM state encoding
//   DIGIT_W        : bits per keypad digit ({a,b})
//   RELOCK_DIGIT   : digit driven while the sender re-locks the controller
//   cnt_width()    : width of the per-state cycle counter
package lock_code_sender_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_CHECK  = 3'd3,
    S_OPEN   = 3'd4,
    S_RELOCK = 3'd5,
    S_CLEAR  = 3'd6
  } state_e;

  localparam int DIGIT_W = 2;
  localparam logic [DIGIT_W-1:0] RELOCK_DIGIT = 2'b00;

  // Wide enough to hold the larger of the two reload values.
  function automatic int cnt_width(input int setup_c, input int open_c);
    return $clog2((setup_c > open_c) ? setup_c : open_c) + 1;
  endfunction

endpackage

// File: rtl/lock_code_sender.sv
// lock_code_sender: serialises a parallel access code onto the lock
// controller's keypad interface, judges the controller's response and
// returns the controller to a clean state afterwards.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           send request (sampled in IDLE only)
//   code            NUM_DIGITS digits, digit 0 in the low two bits
//   lock_out        controller unlocked indication
//   lock_err        controller error indication
//   a, b            current digit (a = digit bit 1, b = digit bit 0)
//   enter           one-cycle digit strobe (also used to re-lock)
//   ctrl_rst        one-cycle reset pulse to the controller
//   busy            high whenever not IDLE
//   done            one-cycle pulse on the first IDLE cycle after a run
//   granted/denied  result of the last run, held until the next start
module lock_code_sender
  import lock_code_sender_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 2,
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned OPEN_CYCLES  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] code,
  input  logic                          lock_out,
  input  logic                          lock_err,
  output logic                          a,
  output logic                          b,
  output logic                          enter,
  output logic                          ctrl_rst,
  output logic                          busy,
  output logic                          done,
  output logic                          granted,
  output logic                          denied
);

  localparam int CODE_W = DIGIT_W * NUM_DIGITS;
  localparam int CW     = cnt_width(SETUP_CYCLES, OPEN_CYCLES);
  localparam int IW     = $clog2(NUM_DIGITS) + 1;

  localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] OPEN_LOAD  = CW'(OPEN_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [IW-1:0]     idx_q;
  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] code_nxt;
  logic              a_q, b_q, enter_q, ctrl_rst_q, done_q;
  logic              granted_q, denied_q;

  // The current digit always sits in the low bits of code_q; advancing to
  // the next digit is a shift by one digit width.
  assign code_nxt = code_q >> DIGIT_W;

  // All outputs come from registers; busy is a pure decode of the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      code_q     <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      enter_q    <= 1'b0;
      ctrl_rst_q <= 1'b0;
      done_q     <= 1'b0;
      granted_q  <= 1'b0;
      denied_q   <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a transition below re-asserts them.
      enter_q    <= 1'b0;
      ctrl_rst_q <= 1'b0;
      done_q     <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            code_q    <= code;
            idx_q     <= '0;
            cnt_q     <= SETUP_LOAD;
            granted_q <= 1'b0;
            denied_q  <= 1'b0;
            a_q       <= code[1];
            b_q       <= code[0];
            state_q   <= S_SETUP;
          end
        end

        S_SETUP: begin
          // A latched controller error makes the rest of the code pointless.
          if (lock_err) begin
            denied_q   <= 1'b1;
            ctrl_rst_q <= 1'b1;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            state_q    <= S_CLEAR;
          end else if (cnt_q == '0) begin
            enter_q <= 1'b1;
            state_q <= S_STROBE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        S_STROBE: begin
          if (idx_q == LAST_IDX) begin
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            state_q <= S_CHECK;
          end else begin
            idx_q   <= idx_q + 1'b1;
            code_q  <= code_nxt;
            a_q     <= code_nxt[1];
            b_q     <= code_nxt[0];
            cnt_q   <= SETUP_LOAD;
            state_q <= S_SETUP;
          end
        end

        S_CHECK: begin
          // Only a clean unlock counts; both-high or both-low are failures.
          if (lock_out && !lock_err) begin
            granted_q <= 1'b1;
            cnt_q     <= OPEN_LOAD;
            a_q       <= RELOCK_DIGIT[1];
            b_q       <= RELOCK_DIGIT[0];
            state_q   <= S_OPEN;
          end else begin
            denied_q   <= 1'b1;
            ctrl_rst_q <= 1'b1;
            state_q    <= S_CLEAR;
          end
        end

        S_OPEN: begin
          if (cnt_q == '0) begin
            // An enter while unlocked drops the controller back to its
            // initial state.
            enter_q <= 1'b1;
            a_q     <= RELOCK_DIGIT[1];
            b_q     <= RELOCK_DIGIT[0];
            state_q <= S_RELOCK;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        S_RELOCK: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end

        S_CLEAR: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign a        = a_q;
  assign b        = b_q;
  assign enter    = enter_q;
  assign ctrl_rst = ctrl_rst_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign granted  = granted_q;
  assign denied   = denied_q;

endmodule
